// File: rtl/elev_call_scheduler.sv
// Four-floor elevator call scheduler: latches car and hall calls, sweeps up and down
// serving them, and drives a one-floor-at-a-time motion handshake plus a door dwell timer.
module elev_call_scheduler #(
  parameter int unsigned DOOR_TIME = 1900
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] car_call,
  input  logic [3:0] hall_up,
  input  logic [3:0] hall_dn,
  output logic       mv_req,
  output logic       mv_dir,
  input  logic       mv_ack,
  output logic [1:0] cur_floor,
  output logic [1:0] dir_state,
  output logic       door_open,
  output logic [3:0] car_pend,
  output logic [3:0] up_pend,
  output logic [3:0] dn_pend
);

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_ARRIVE, S_DOOR, S_DECIDE} state_t;
  typedef enum logic [1:0] {D_IDLE = 2'b00, D_UP = 2'b01, D_DN = 2'b10} dir_t;

  localparam logic [15:0] DOOR_LAST = 16'(DOOR_TIME - 1);
  localparam logic [3:0]  ALL_ONES  = '1;

  state_t      state_q, state_n;
  dir_t        dir_q, dir_n;
  logic [1:0]  floor_q, floor_n;
  logic [15:0] cnt_q, cnt_n;
  logic [3:0]  car_q, up_q, dn_q;
  logic [3:0]  car_n, up_n, dn_n;

  logic [3:0]  car_eff, up_eff, dn_eff, any_eff;
  logic [3:0]  fbit, above_mask, below_mask;
  logic        above, below, here_any, car_here, up_here, dn_here;
  logic        going_up, ahead, behind, same_here, opp_here, end_floor;
  logic        clr_car, clr_up, clr_dn;
  dir_t        flip;

  // Decisions see this cycle's button presses as well as latched calls.
  assign car_eff    = car_q | car_call;
  assign up_eff     = up_q  | (hall_up & 4'b0111);
  assign dn_eff     = dn_q  | (hall_dn & 4'b1110);
  assign any_eff    = car_eff | up_eff | dn_eff;

  assign fbit       = 4'b0001 << floor_q;
  assign above_mask = 4'b1110 << floor_q;
  assign below_mask = ~(ALL_ONES << floor_q);
  assign above      = |(any_eff & above_mask);
  assign below      = |(any_eff & below_mask);
  assign here_any   = |(any_eff & fbit);
  assign car_here   = |(car_eff & fbit);
  assign up_here    = |(up_eff & fbit);
  assign dn_here    = |(dn_eff & fbit);

  assign going_up   = (dir_q == D_UP);
  assign ahead      = going_up ? above : below;
  assign behind     = going_up ? below : above;
  assign same_here  = going_up ? up_here : dn_here;
  assign opp_here   = going_up ? dn_here : up_here;
  assign end_floor  = going_up ? (floor_q == 2'd3) : (floor_q == 2'd0);
  assign flip       = going_up ? D_DN : D_UP;

  always_comb begin
    state_n   = state_q;
    dir_n     = dir_q;
    floor_n   = floor_q;
    cnt_n     = cnt_q;
    clr_car   = 1'b0;
    clr_up    = 1'b0;
    clr_dn    = 1'b0;
    mv_req    = 1'b0;
    door_open = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (here_any) begin
          state_n = S_DOOR;
          cnt_n   = '0;
          clr_car = 1'b1;
          clr_up  = 1'b1;
          clr_dn  = 1'b1;
        end else if (above) begin
          dir_n   = D_UP;
          state_n = S_MOVE;
        end else if (below) begin
          dir_n   = D_DN;
          state_n = S_MOVE;
        end
      end

      S_MOVE: begin
        mv_req = 1'b1;
        if (mv_ack) begin
          if (going_up && floor_q != 2'd3)
            floor_n = floor_q + 2'd1;
          else if (dir_q == D_DN && floor_q != 2'd0)
            floor_n = floor_q - 2'd1;
          state_n = S_ARRIVE;
        end
      end

      S_ARRIVE: begin
        if (car_here || same_here || end_floor || (opp_here && !ahead)) begin
          state_n = S_DOOR;
          cnt_n   = '0;
          clr_car = 1'b1;
          if (going_up) clr_up = 1'b1;
          else          clr_dn = 1'b1;
          // Nothing left ahead: the hall call for the other way is answered by this stop.
          if (!ahead) begin
            if (going_up) clr_dn = 1'b1;
            else          clr_up = 1'b1;
            dir_n = flip;
          end
        end else begin
          state_n = S_MOVE;
        end
      end

      S_DOOR: begin
        door_open = 1'b1;
        clr_car   = 1'b1;
        if (dir_q == D_IDLE) begin
          clr_up = 1'b1;
          clr_dn = 1'b1;
        end else if (going_up) begin
          clr_up = 1'b1;
        end else begin
          clr_dn = 1'b1;
        end
        if (cnt_q == DOOR_LAST) begin
          state_n = S_DECIDE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end

      S_DECIDE: begin
        if (dir_q == D_IDLE) begin
          if (above) begin
            dir_n   = D_UP;
            state_n = S_MOVE;
          end else if (below) begin
            dir_n   = D_DN;
            state_n = S_MOVE;
          end else if (here_any) begin
            state_n = S_DOOR;
            cnt_n   = '0;
            clr_car = 1'b1;
            clr_up  = 1'b1;
            clr_dn  = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else if (ahead) begin
          state_n = S_MOVE;
        end else if (behind) begin
          dir_n   = flip;
          state_n = S_MOVE;
        end else if (opp_here) begin
          if (going_up) clr_dn = 1'b1;
          else          clr_up = 1'b1;
          dir_n   = flip;
          state_n = S_DOOR;
          cnt_n   = '0;
        end else begin
          dir_n   = D_IDLE;
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Clears only ever target the served floor, so clear beats set there and set wins elsewhere.
  assign car_n = car_eff & ~(clr_car ? fbit : 4'b0000);
  assign up_n  = up_eff  & ~(clr_up  ? fbit : 4'b0000);
  assign dn_n  = dn_eff  & ~(clr_dn  ? fbit : 4'b0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= D_IDLE;
      floor_q <= '0;
      cnt_q   <= '0;
      car_q   <= '0;
      up_q    <= '0;
      dn_q    <= '0;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      floor_q <= floor_n;
      cnt_q   <= cnt_n;
      car_q   <= car_n;
      up_q    <= up_n;
      dn_q    <= dn_n;
    end
  end

  assign mv_dir    = going_up;
  assign dir_state = dir_q;
  assign cur_floor = floor_q;
  assign car_pend  = car_q;
  assign up_pend   = up_q;
  assign dn_pend   = dn_q;

endmodule

// File: tb/tb_elev_call_scheduler.sv
// Directed bench for elev_call_scheduler: reset, single trips, stop rules, door dwell,
// ignored acks, reset during door, and a full up/down sweep with every button pressed.
module tb_elev_call_scheduler;

  localparam int unsigned DT = 1900;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] car_call, hall_up, hall_dn;
  logic       mv_req, mv_dir, mv_ack;
  logic [1:0] cur_floor, dir_state;
  logic       door_open;
  logic [3:0] car_pend, up_pend, dn_pend;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  elev_call_scheduler #(.DOOR_TIME(DT)) dut (
    .clk       (clk),
    .rst       (rst),
    .car_call  (car_call),
    .hall_up   (hall_up),
    .hall_dn   (hall_dn),
    .mv_req    (mv_req),
    .mv_dir    (mv_dir),
    .mv_ack    (mv_ack),
    .cur_floor (cur_floor),
    .dir_state (dir_state),
    .door_open (door_open),
    .car_pend  (car_pend),
    .up_pend   (up_pend),
    .dn_pend   (dn_pend)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack();
    mv_ack = 1'b1;
    tick();
    mv_ack = 1'b0;
  endtask

  // Called with the door just opened; returns on the first sample with the door closed.
  task automatic door_dwell(input string tag);
    int n;
    n = door_open ? 1 : 0;
    while (door_open && n <= int'(DT) + 8) begin
      tick();
      if (door_open) n++;
    end
    chk(tag, 16'(n), 16'(DT));
  endtask

  // Answers every move request until the door opens, within a fixed cycle budget.
  task automatic to_door(input string tag);
    int k;
    k = 0;
    while (!door_open && k < 64) begin
      if (mv_req) mv_ack = 1'b1;
      tick();
      mv_ack = 1'b0;
      k++;
    end
    chk(tag, 16'(door_open), 16'd1);
  endtask

  logic [1:0] sw_floor [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
  logic [1:0] sw_dir   [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
  logic [3:0] sw_car   [5] = '{4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] sw_dn    [5] = '{4'b1110, 4'b1110, 4'b0110, 4'b0010, 4'b0000};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; car_call = '0; hall_up = '0; hall_dn = '0; mv_ack = 1'b0;
    tick();
    car_call = '1; hall_up = '1; hall_dn = '1;
    tick();
    chk("rst_floor", 16'(cur_floor), 16'd0);
    chk("rst_dir",   16'(dir_state), 16'd0);
    chk("rst_mvreq", 16'(mv_req),    16'd0);
    chk("rst_mvdir", 16'(mv_dir),    16'd0);
    chk("rst_door",  16'(door_open), 16'd0);
    chk("rst_pend",  16'({car_pend, up_pend, dn_pend}), 16'h000);
    car_call = '0; hall_up = '0; hall_dn = '0;
    rst = 1'b0;

    // Car call to floor 3 from floor 1.
    car_call = 4'b0100; tick(); car_call = '0;
    chk("t1_mvreq", 16'(mv_req),    16'd1);
    chk("t1_mvdir", 16'(mv_dir),    16'd1);
    chk("t1_dir",   16'(dir_state), 16'b01);
    chk("t1_carp",  16'(car_pend),  16'b0100);
    tick(); tick();
    chk("t1_hold_req",   16'(mv_req),    16'd1);
    chk("t1_hold_floor", 16'(cur_floor), 16'd0);
    ack();
    chk("t1_f1",     16'(cur_floor), 16'd1);
    chk("t1_arrreq", 16'(mv_req),    16'd0);
    tick();
    chk("t1_pass", 16'(mv_req), 16'd1);
    ack();
    chk("t1_f2", 16'(cur_floor), 16'd2);
    tick();
    chk("t1_door", 16'(door_open), 16'd1);
    chk("t1_carc", 16'(car_pend),  16'b0000);
    chk("t1_flip", 16'(dir_state), 16'b10);
    door_dwell("t1_dwell");
    tick();
    chk("t1_idle_dir", 16'(dir_state), 16'b00);
    chk("t1_idle_req", 16'(mv_req),    16'd0);

    // Stray ack while idle.
    ack();
    chk("ack_idle_floor", 16'(cur_floor), 16'd2);

    // Door at current floor, stray ack and in-door calls, then reset mid-door.
    car_call = 4'b0100; tick(); car_call = '0;
    chk("d_open", 16'(door_open), 16'd1);
    chk("d_carc", 16'(car_pend),  16'b0000);
    ack();
    chk("d_ack_floor", 16'(cur_floor), 16'd2);
    chk("d_ack_door",  16'(door_open), 16'd1);
    hall_up = 4'b0100; tick(); hall_up = '0;
    chk("d_upclr", 16'(up_pend), 16'b0000);
    car_call = 4'b0001; tick(); car_call = '0;
    chk("d_carset", 16'(car_pend), 16'b0001);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("d_rst_door",  16'(door_open), 16'd0);
    chk("d_rst_pend",  16'({car_pend, up_pend, dn_pend}), 16'h000);
    chk("d_rst_floor", 16'(cur_floor), 16'd0);

    // Car call at the current floor opens the door without moving.
    car_call = 4'b0001; tick(); car_call = '0;
    chk("h_door",  16'(door_open), 16'd1);
    chk("h_mvreq", 16'(mv_req),    16'd0);
    chk("h_carc",  16'(car_pend),  16'b0000);
    door_dwell("h_dwell");
    tick();
    chk("h_idle_dir", 16'(dir_state), 16'b00);
    chk("h_idle_req", 16'(mv_req),    16'd0);

    // Down call at floor 3 and up call at floor 2 together.
    hall_dn = 4'b0100; hall_up = 4'b0010; tick(); hall_dn = '0; hall_up = '0;
    chk("m_mvreq", 16'(mv_req),  16'd1);
    chk("m_mvdir", 16'(mv_dir),  16'd1);
    chk("m_upp",   16'(up_pend), 16'b0010);
    chk("m_dnp",   16'(dn_pend), 16'b0100);
    ack(); tick();
    chk("m_stop2_door", 16'(door_open), 16'd1);
    chk("m_stop2_up",   16'(up_pend),   16'b0000);
    chk("m_stop2_dn",   16'(dn_pend),   16'b0100);
    chk("m_stop2_dir",  16'(dir_state), 16'b01);
    door_dwell("m_dwell2");
    tick();
    chk("m_cont_req", 16'(mv_req), 16'd1);
    chk("m_cont_dir", 16'(mv_dir), 16'd1);
    ack(); tick();
    chk("m_stop3_floor", 16'(cur_floor), 16'd2);
    chk("m_stop3_door",  16'(door_open), 16'd1);
    chk("m_stop3_dn",    16'(dn_pend),   16'b0000);
    chk("m_stop3_dir",   16'(dir_state), 16'b10);
    door_dwell("m_dwell3");
    tick();
    chk("m_idle_dir", 16'(dir_state), 16'b00);

    // Moving up with a call behind and hall_up[3] held: must reverse at floor 3.
    rst = 1'b1; tick(); rst = 1'b0;
    car_call = 4'b0100; tick(); car_call = '0;
    ack(); tick();
    car_call = 4'b0001; hall_up = 4'b1000; tick(); car_call = '0;
    chk("r_carp", 16'(car_pend), 16'b0101);
    chk("r_upp",  16'(up_pend),  16'b0000);
    ack(); tick();
    chk("r_door",  16'(door_open), 16'd1);
    chk("r_floor", 16'(cur_floor), 16'd2);
    chk("r_dir",   16'(dir_state), 16'b10);
    chk("r_carp2", 16'(car_pend),  16'b0001);
    door_dwell("r_dwell");
    tick();
    chk("r_rev_req", 16'(mv_req), 16'd1);
    chk("r_rev_dir", 16'(mv_dir), 16'd0);
    hall_up = '0;
    to_door("r_home");
    chk("r_home_floor", 16'(cur_floor), 16'd0);
    chk("r_home_carp",  16'(car_pend),  16'b0000);
    chk("r_home_dir",   16'(dir_state), 16'b01);
    rst = 1'b1; tick(); rst = 1'b0;

    // Every button pressed at floor 1.
    car_call = '1; hall_up = '1; hall_dn = '1; tick();
    car_call = '0; hall_up = '0; hall_dn = '0;
    chk("s_door0", 16'(door_open), 16'd1);
    chk("s_car0",  16'(car_pend),  16'b1110);
    chk("s_up0",   16'(up_pend),   16'b0110);
    chk("s_dn0",   16'(dn_pend),   16'b1110);
    for (int i = 0; i < 5; i++) begin
      door_dwell("s_dwell");
      to_door("s_stop");
      chk($sformatf("s_floor%0d", i), 16'(cur_floor), 16'(sw_floor[i]));
      chk($sformatf("s_dir%0d", i),   16'(dir_state), 16'(sw_dir[i]));
      chk($sformatf("s_car%0d", i),   16'(car_pend),  16'(sw_car[i]));
      chk($sformatf("s_dn%0d", i),    16'(dn_pend),   16'(sw_dn[i]));
    end
    door_dwell("s_dwell_last");
    tick();
    chk("s_end_dir",  16'(dir_state), 16'b00);
    chk("s_end_pend", 16'({car_pend, up_pend, dn_pend}), 16'h000);
    chk("s_end_req",  16'(mv_req),    16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
